// File: rtl/ula_pkg.sv
// Shared opcode encodings, FSM state type and flag bit positions for the ula_pipe ALU.
package ula_pkg;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_XOR = 4'b0010;
    localparam logic [3:0] OP_NOT = 4'b0011;
    localparam logic [3:0] OP_AND = 4'b0100;
    localparam logic [3:0] OP_OR  = 4'b0101;
    localparam logic [3:0] OP_EQ  = 4'b0110;
    localparam logic [3:0] OP_NE  = 4'b0111;
    localparam logic [3:0] OP_SHL = 4'b1000;
    localparam logic [3:0] OP_SHR = 4'b1001;
    localparam logic [3:0] OP_MUL = 4'b1010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int unsigned FLAG_C = 0;
    localparam int unsigned FLAG_Z = 1;
    localparam int unsigned FLAG_N = 2;
    localparam int unsigned FLAG_V = 3;

    function automatic logic [3:0] pack_flags(input logic v, input logic n,
                                              input logic z, input logic c);
        logic [3:0] f;
        f         = '0;
        f[FLAG_V] = v;
        f[FLAG_N] = n;
        f[FLAG_Z] = z;
        f[FLAG_C] = c;
        return f;
    endfunction

endpackage

// File: rtl/ula_pipe_if.sv
// Request/response bundle of the ula_pipe ALU; master is the requester/consumer side.
interface ula_pipe_if #(parameter int W = 8);

    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   opcode;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] s;
    logic [3:0]   flags;
    logic         err;
    logic         out_valid;
    logic         out_ready;

    modport master (
        output a, b, opcode, in_valid, out_ready,
        input  in_ready, s, flags, err, out_valid
    );

    modport slave (
        input  a, b, opcode, in_valid, out_ready,
        output in_ready, s, flags, err, out_valid
    );

endinterface

// File: rtl/ula_mul_seq.sv
// Iterative unsigned shift-add multiplier: one partial product per cycle, W cycles total.
module ula_mul_seq #(
    parameter int W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    output logic             busy,
    output logic             done,
    output logic [2*W-1:0]   product
);

    localparam int CW = $clog2(W + 1);

    logic [2*W-1:0] mcand;
    logic [2*W-1:0] acc;
    logic [W-1:0]   mplier;
    logic [CW-1:0]  count;

    // Partial product 0 is folded into the start edge, so done is already high
    // during the W-th cycle and the caller can register the product on that edge.
    assign done    = busy && (count == CW'(W));
    assign product = acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand  <= '0;
            acc    <= '0;
            mplier <= '0;
            count  <= '0;
            busy   <= 1'b0;
        end else if (start) begin
            acc    <= b[0] ? {{W{1'b0}}, a} : '0;
            mcand  <= {{W{1'b0}}, a} << 1;
            mplier <= b >> 1;
            count  <= CW'(1);
            busy   <= 1'b1;
        end else if (busy) begin
            if (done) begin
                busy <= 1'b0;
            end else begin
                if (mplier[0]) begin
                    acc <= acc + mcand;
                end
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                count  <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ula_pipe.sv
// Registered ALU with valid/ready handshake; single-cycle ops plus an iterative multiply.
module ula_pipe
    import ula_pkg::*;
#(
    parameter int W = 8
) (
    input  logic      clk,
    input  logic      rst,
    ula_pipe_if.slave bus
);

    localparam int SW = $clog2(W);

    state_t         state;
    state_t         state_next;
    logic           accept;
    logic           is_mul;
    logic           load_mul;
    logic           mul_busy;
    logic           mul_done;
    logic [2*W-1:0] product;

    logic [W:0]     sum;
    logic [W:0]     diff;
    logic [2*W-1:0] shl_ext;
    logic [2*W-1:0] shr_ext;
    logic [SW-1:0]  sh;
    logic [W-1:0]   res;
    logic           res_v;
    logic           res_c;
    logic           res_err;
    logic [3:0]     res_flags;
    logic [3:0]     mul_flags;

    logic [W-1:0]   s_q;
    logic [3:0]     flags_q;
    logic           err_q;

    assign bus.in_ready  = (state == ST_IDLE) || ((state == ST_DONE) && bus.out_ready);
    assign bus.out_valid = (state == ST_DONE);
    assign bus.s         = s_q;
    assign bus.flags     = flags_q;
    assign bus.err       = err_q;

    assign accept   = bus.in_valid && bus.in_ready;
    assign is_mul   = (bus.opcode == OP_MUL);
    assign load_mul = (state == ST_MUL) && mul_busy && mul_done;

    ula_mul_seq #(.W(W)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (accept && is_mul),
        .a       (bus.a),
        .b       (bus.b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (product)
    );

    // Shifts run in a 2W-wide field so the last bit shifted out lands at a fixed index.
    always_comb begin
        sh      = bus.b[SW-1:0];
        sum     = {1'b0, bus.a} + {1'b0, bus.b};
        diff    = {1'b0, bus.a} - {1'b0, bus.b};
        shl_ext = {{W{1'b0}}, bus.a} << sh;
        shr_ext = {bus.a, {W{1'b0}}} >> sh;
        res     = '0;
        res_v   = 1'b0;
        res_c   = 1'b0;
        res_err = 1'b0;
        case (bus.opcode)
            OP_ADD: begin
                res   = sum[W-1:0];
                res_c = sum[W];
                res_v = (bus.a[W-1] == bus.b[W-1]) && (sum[W-1] != bus.a[W-1]);
            end
            OP_SUB: begin
                res   = diff[W-1:0];
                res_c = diff[W];
                res_v = (bus.a[W-1] != bus.b[W-1]) && (diff[W-1] != bus.a[W-1]);
            end
            OP_XOR: res = bus.a ^ bus.b;
            OP_NOT: res = ~bus.a;
            OP_AND: res = bus.a & bus.b;
            OP_OR:  res = bus.a | bus.b;
            OP_EQ:  res[0] = (bus.a == bus.b);
            OP_NE:  res[0] = (bus.a != bus.b);
            OP_SHL: begin
                res   = shl_ext[W-1:0];
                res_c = shl_ext[W];
            end
            OP_SHR: begin
                res   = shr_ext[2*W-1:W];
                res_c = shr_ext[W-1];
            end
            OP_MUL: res = '0;
            default: res_err = 1'b1;
        endcase
        res_flags = res_err ? 4'b0000 : pack_flags(res_v, res[W-1], (res == '0), res_c);
        mul_flags = pack_flags(1'b0, product[W-1], (product[W-1:0] == '0),
                               |product[2*W-1:W]);
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_next = is_mul ? ST_MUL : ST_DONE;
                end
            end
            ST_MUL: begin
                if (load_mul) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (accept) begin
                    state_next = is_mul ? ST_MUL : ST_DONE;
                end else if (bus.out_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            s_q     <= '0;
            flags_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state <= state_next;
            if (accept && !is_mul) begin
                s_q     <= res;
                flags_q <= res_flags;
                err_q   <= res_err;
            end else if (load_mul) begin
                s_q     <= product[W-1:0];
                flags_q <= mul_flags;
                err_q   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ula_pipe.sv
// Self-checking bench for ula_pipe (W=8): vector table, random ops against a model, corner sequences.
module tb_ula_pipe;
    import ula_pkg::*;

    localparam int W = 8;

    typedef struct {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] s;
        logic [3:0] flags;
        logic       err;
    } vec_t;

    typedef struct {
        logic [7:0] s;
        logic [3:0] flags;
        logic       err;
        int         acc_cyc;
        int         lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   first_cyc = 0;
    bit   seen = 1'b0;
    bit   rnd = 1'b0;
    exp_t q[$];

    ula_pipe_if #(.W(W)) bus ();

    ula_pipe #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // flags written as {V,N,Z,C}
    vec_t tbl [23] = '{
        '{OP_ADD, 8'd200, 8'd100, 8'h2C, 4'b0001, 1'b0},
        '{OP_SUB, 8'd5,   8'd7,   8'hFE, 4'b0101, 1'b0},
        '{OP_SUB, 8'h80,  8'h01,  8'h7F, 4'b1000, 1'b0},
        '{OP_ADD, 8'h7F,  8'h01,  8'h80, 4'b1100, 1'b0},
        '{OP_ADD, 8'hFF,  8'h01,  8'h00, 4'b0011, 1'b0},
        '{OP_XOR, 8'hAA,  8'hAA,  8'h00, 4'b0010, 1'b0},
        '{OP_NOT, 8'h0F,  8'h55,  8'hF0, 4'b0100, 1'b0},
        '{OP_AND, 8'hF0,  8'h3C,  8'h30, 4'b0000, 1'b0},
        '{OP_OR,  8'h81,  8'h02,  8'h83, 4'b0100, 1'b0},
        '{OP_EQ,  8'h12,  8'h12,  8'h01, 4'b0000, 1'b0},
        '{OP_EQ,  8'h12,  8'h13,  8'h00, 4'b0010, 1'b0},
        '{OP_NE,  8'h12,  8'h13,  8'h01, 4'b0000, 1'b0},
        '{OP_SHL, 8'h81,  8'h01,  8'h02, 4'b0001, 1'b0},
        '{OP_SHL, 8'h81,  8'h08,  8'h81, 4'b0100, 1'b0},
        '{OP_SHR, 8'h81,  8'h01,  8'h40, 4'b0001, 1'b0},
        '{OP_SHR, 8'h80,  8'h07,  8'h01, 4'b0000, 1'b0},
        '{OP_SHL, 8'h01,  8'h07,  8'h80, 4'b0100, 1'b0},
        '{OP_MUL, 8'd15,  8'd17,  8'hFF, 4'b0100, 1'b0},
        '{OP_MUL, 8'd16,  8'd16,  8'h00, 4'b0011, 1'b0},
        '{OP_MUL, 8'd0,   8'd200, 8'h00, 4'b0010, 1'b0},
        '{4'b1011, 8'h12, 8'h34,  8'h00, 4'b0000, 1'b1},
        '{4'b1111, 8'hFF, 8'hFF,  8'h00, 4'b0000, 1'b1},
        '{OP_SUB, 8'h10,  8'h10,  8'h00, 4'b0010, 1'b0}
    };

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                                  output logic [7:0] s, output logic [3:0] f, output logic e);
        int ia, ib, sa, sb, r, k;
        bit c, v;
        ia = a; ib = b;
        sa = (ia >= 128) ? ia - 256 : ia;
        sb = (ib >= 128) ? ib - 256 : ib;
        k = ib % 8;
        r = 0; c = 0; v = 0; e = 0;
        case (op)
            OP_ADD: begin r = ia + ib; c = (r > 255); v = (sa + sb > 127) || (sa + sb < -128); end
            OP_SUB: begin r = ia - ib; c = (ia < ib); v = (sa - sb > 127) || (sa - sb < -128); end
            OP_XOR: r = ia ^ ib;
            OP_NOT: r = ~ia;
            OP_AND: r = ia & ib;
            OP_OR:  r = ia | ib;
            OP_EQ:  r = (ia == ib) ? 1 : 0;
            OP_NE:  r = (ia != ib) ? 1 : 0;
            OP_SHL: begin r = ia << k; c = (k != 0) && (((ia << k) / 256) % 2 == 1); end
            OP_SHR: begin r = ia >> k; c = (k != 0) && (((ia >> (k - 1)) % 2) == 1); end
            OP_MUL: begin r = ia * ib; c = (r > 255); end
            default: e = 1;
        endcase
        s = e ? 8'h00 : 8'(r & 255);
        f = e ? 4'b0000 : {v, s[7], (s == 8'h00), c};
    endfunction

    task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] es, input logic [3:0] ef, input logic ee,
                         output int waited);
        exp_t e;
        bit   got;
        got = 0;
        waited = 0;
        bus.opcode = op; bus.a = a; bus.b = b; bus.in_valid = 1'b1;
        for (int t = 0; t < 200 && !got; t++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                e.s = es; e.flags = ef; e.err = ee;
                e.acc_cyc = cyc;
                e.lat = (op == OP_MUL) ? W + 1 : 1;
                q.push_back(e);
                got = 1;
            end else begin
                waited++;
            end
            @(posedge clk); #1;
            if (rnd) bus.out_ready = 1'($urandom_range(0, 1));
        end
        bus.in_valid = 1'b0;
        if (!got) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        bus.out_ready = 1'b1;
        for (int t = 0; t < 100; t++) begin
            if (q.size() == 0) break;
            @(posedge clk); #1;
        end
        chk("drain_empty", q.size(), 0);
    endtask

    // Scoreboard: pop on every handshaken result; latency is measured from the first valid cycle.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            seen = 1'b0;
        end else begin
            if (bus.out_valid && !seen) begin
                seen = 1'b1;
                first_cyc = cyc;
            end
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_result", {bus.err, bus.flags, bus.s}, 32'hFFFF_FFFF);
                end else begin
                    e = q.pop_front();
                    chk("result_s_flags_err", {bus.err, bus.flags, bus.s}, {e.err, e.flags, e.s});
                    chk("result_latency", first_cyc - e.acc_cyc, e.lat);
                end
                seen = 1'b0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int         w;
        logic [3:0] op;
        logic [7:0] ra, rb, es;
        logic [3:0] ef;
        logic       ee;
        bit         leaked;

        bus.a = '0; bus.b = '0; bus.opcode = '0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_out_valid", bus.out_valid, 0);
        chk("reset_in_ready", bus.in_ready, 1);
        chk("reset_s_flags_err", {bus.err, bus.flags, bus.s}, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 23; i++) begin
            issue(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].flags, tbl[i].err, w);
        end
        drain();

        rnd = 1'b1;
        for (int i = 0; i < 40; i++) begin
            op = (i % 4 == 3) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 10));
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            model(op, ra, rb, es, ef, ee);
            issue(op, ra, rb, es, ef, ee, w);
        end
        rnd = 1'b0;
        drain();

        // Held result under back-pressure, then a same-edge accept as it drains.
        bus.out_ready = 1'b0;
        issue(OP_SHL, 8'h81, 8'h01, 8'h02, 4'b0001, 1'b0, w);
        bus.a = 8'hFF; bus.b = 8'h03; bus.opcode = OP_ADD;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_out_valid", bus.out_valid, 1);
            chk("stall_in_ready", bus.in_ready, 0);
            chk("stall_s_flags", {bus.flags, bus.s}, {4'b0001, 8'h02});
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        issue(OP_ADD, 8'd3, 8'd4, 8'd7, 4'b0000, 1'b0, w);
        chk("stall_release_accept_wait", w, 0);
        drain();

        // Reset three cycles into a multiply, with a request presented during reset.
        issue(OP_MUL, 8'd15, 8'd17, 8'hFF, 4'b0100, 1'b0, w);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        bus.in_valid = 1'b1; bus.opcode = OP_ADD; bus.a = 8'd1; bus.b = 8'd1;
        @(posedge clk); #1;
        rst = 1'b0;
        bus.in_valid = 1'b0;
        q.delete();
        @(negedge clk);
        chk("rst_mul_out_valid", bus.out_valid, 0);
        chk("rst_mul_in_ready", bus.in_ready, 1);
        chk("rst_mul_s_flags_err", {bus.err, bus.flags, bus.s}, 0);
        leaked = 1'b0;
        for (int i = 0; i < W + 3; i++) begin
            @(negedge clk);
            if (bus.out_valid) leaked = 1'b1;
        end
        chk("rst_no_stale_result", leaked, 0);
        @(posedge clk); #1;

        issue(4'b1111, 8'h5A, 8'hA5, 8'h00, 4'b0000, 1'b1, w);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ula_pipe.md
ULA_PIPE -- requirements
Module: ula_pipe

Interface
REQ-001 Parameter W, default 8, operand/result width in bits; legal range 4..32.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 a  input  W  operand A.
REQ-005 b  input  W  operand B; low $clog2(W) bits are the shift amount for shifts.
REQ-006 opcode  input  4  operation select.
REQ-007 in_valid  input  1  operation request.
REQ-008 in_ready  output  1  block accepts a request this cycle.
REQ-009 s  output  W  registered result.
REQ-010 flags  output  4  registered {V,N,Z,C}: overflow, negative, zero, carry/borrow.
REQ-011 err  output  1  registered illegal-opcode indicator.
REQ-012 out_valid  output  1  s/flags/err hold a completed result.
REQ-013 out_ready  input  1  consumer takes the result this cycle.

Function
REQ-014 Opcodes: 0000 ADD, 0001 SUB, 0010 XOR, 0011 NOT A, 0100 AND, 0101 OR, 0110 EQ, 0111 NE, 1000 SHL, 1001 SHR (logical), 1010 MUL; 1011-1111 illegal.
REQ-015 Acceptance occurs on an edge where in_valid and in_ready are both 1; a, b and opcode are captured then.
REQ-016 FSM states IDLE, MUL, DONE; IDLE->DONE on accepting a non-MUL op; IDLE->MUL on accepting MUL; MUL->DONE after W cycles; DONE->IDLE on out_ready without a new acceptance.
REQ-017 in_ready = (state==IDLE) or (state==DONE and out_ready); acceptance in DONE with out_ready goes straight to DONE or MUL, giving one op per cycle for single-cycle ops.
REQ-018 Single-cycle ops: s/flags/err load on the accepting edge; out_valid is 1 in the following cycle (latency 1).
REQ-019 MUL: unsigned shift-add, one partial product per cycle; out_valid is 1 exactly W+1 cycles after the accepting edge; s = low W bits of product.
REQ-020 out_valid = (state==DONE); s/flags/err are stable while out_valid=1 and out_ready=0.
REQ-021 Results: ADD/SUB modulo 2^W; EQ/NE give 1 or 0 zero-extended to W; NOT ignores b.
REQ-022 C: ADD carry-out; SUB borrow (a<b unsigned); SHL/SHR last bit shifted out, 0 for shift amount 0; MUL 1 if upper W product bits nonzero; otherwise 0.
REQ-023 V: signed overflow for ADD/SUB only, else 0; N = s[W-1]; Z = (s==0), for every legal op.
REQ-024 Illegal opcode: s=0, flags=0, err=1, latency 1; err=0 for legal ops.
REQ-025 Operands latched at acceptance; changes on a/b/opcode during MUL or DONE have no effect.

Reset
REQ-026 rst=1 on an edge forces state IDLE, s=0, flags=0, err=0, multiplier registers 0; in_ready=1 and out_valid=0 in the next cycle.
REQ-027 rst overrides everything, including an in-progress MUL or a pending result; in_valid during rst is not accepted.

Structure
REQ-028 Package ula_pkg holds the 4-bit opcode constants, the state enum and the flag bit positions.
REQ-029 Sub-module ula_mul_seq (parameter W) implements the iterative multiplier with start, busy, done and a 2W-bit product.
REQ-030 All single-cycle ops are one combinational datapath feeding the output registers; no tristate buses.

Verification (W=8)
REQ-031 ADD a=200, b=100 -> s=0x2C, C=1, Z=0, V=0, out_valid one cycle after acceptance.
REQ-032 SUB 5-7 -> s=0xFE, C=1, N=1, V=0; SUB 0x80-0x01 -> s=0x7F, V=1, C=0.
REQ-033 MUL 15*17 -> s=0xFF, C=0, out_valid exactly 9 cycles after accept; MUL 16*16 -> s=0x00, C=1, Z=1.
REQ-034 SHL 0x81 by 1 -> s=0x02, C=1; out_ready held low 3 cycles -> s/flags stable, in_ready=0; then out_ready=1 with in_valid=1 ADD -> accepted that edge, next result valid the following cycle.
REQ-035 rst pulsed 3 cycles into a MUL -> next cycle out_valid=0, in_ready=1, s=0, flags=0; opcode 1111 after reset -> err=1, s=0.
